encoder83_serializer: RTL and testbench
=======================================

# encoder83_serializer

Registered 8-to-3 priority encoder with a valid/ready output handshake: the encode-side counterpart of the team's 3-to-8 decoders. It latches one-cycle request pulses on eight lines into a pending register and issues one 3-bit index per accepted transfer, highest priority first. Downstream logic, including the existing decoder38, can regenerate the one-hot line from each code. It sits between event sources and a single-code consumer, so simultaneous events are serialized instead of lost.

## Interface
- MSB_FIRST, default 1: 1 gives bit 7 the highest priority; 0 gives bit 0 the highest priority.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request pulses; each set bit marks an event on that line.
- ready  input  1  downstream accepts the code this cycle.
- code  output  3  encoded index of the granted line.
- valid  output  1  code is valid.
- pending  output  8  current pending register, for observation.
- ovf  output  1  sticky flag: a request was merged into an already-pending bit.
- ovf_clr  input  1  synchronous clear of ovf.

## Operation
- Reset values: pending=8'h00, code=3'd0, valid=0, ovf=0.
- State is implied by valid:
  - EMPTY (valid=0).
  - HOLD (valid=1).
- load condition: (valid==0) or (valid && ready).
- Per rising edge:
  - pending_next = (pending & ~grant_mask) | req.
  - grant_mask is the one-hot of the selected bit when load is true and pending is non-zero; otherwise 0.
  - Selection uses only the pending register, never req in the same cycle.
- On a load with pending != 0:
  - code <= index of the priority bit per MSB_FIRST.
  - valid <= 1.
  - That bit is cleared from pending.
- On a load with pending == 0: valid <= 0 and code holds its value.
- HOLD with ready=0: code and valid are frozen and pending keeps accumulating.
- A req bit that lands on the bit being granted in the same cycle stays pending. It is a new event, not an overflow.
- ovf is set when (req & pending & ~grant_mask) != 0. The original and new events merge into one code.
- Priority of ovf updates: ovf_clr and a new overflow in the same cycle leave ovf=1 (set wins).
- req=8'hFF in one cycle queues all eight bits. They are delivered as eight codes over eight handshakes.
- Asynchronous reset mid-transfer clears everything immediately. A code that was not accepted is discarded.

## Timing
- Latency from req to valid is 2 cycles: req is captured into pending at edge 1, and code/valid load at edge 2.
- Throughput is one code per cycle while ready=1 and pending is non-empty.
- Back-to-back: with ready held at 1, a new code loads on the same edge that the previous code is accepted.
- ready has no combinational path to code or valid. All outputs come straight from registers.
- ovf rises one edge after the offending req.

## Structure
- Shared package encoder_pkg holds:
  - LINES=8.
  - CODE_W=3.
  - The constant used as the MSB_FIRST default.
- Sub-module priority_enc83: purely combinational.
  - Inputs: 8-bit vector and MSB_FIRST.
  - Outputs: 3-bit index, any flag, and the one-hot grant_mask.
- Top level holds:
  - The pending register.
  - The output register and handshake.
  - The ovf logic.

## Test plan
- Reset and single event: reset, then req=8'h08 for 1 cycle with ready=1 → valid=1 and code=3 at edge 2, valid=0 the next cycle, pending=0.
- Simultaneous events with MSB_FIRST=1: req=8'h81 for 1 cycle, ready=1 → codes 7 then 0 on consecutive cycles. With MSB_FIRST=0 the order is 0 then 7.
- Backpressure: req=8'h24 with ready=0 → valid=1 and code=5 held for 10 cycles, pending=8'h04. Raise ready → code 2 on the next cycle, then valid=0.
- Overflow: req=8'h10, hold ready=0 so code 4 sits in HOLD, then pulse req=8'h11 twice (bit 0 is already pending on the second pulse) → ovf=1. Pulse ovf_clr together with a further req=8'h01 → ovf stays 1. Pulse ovf_clr alone → ovf=0.
- Grant/request collision: pending=8'h02, ready=1, and req=8'h02 on the granting edge → code=1 issued, bit 1 still pending, ovf=0, second code 1 on the next cycle.
- Reset mid-operation: req=8'hFF, accept 3 codes, then assert rst asynchronously between edges → pending=0, valid=0, code=0 immediately. No codes are issued after release.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared constants for the 8-to-3 encoder/serializer.
// Line count, code width and the default priority direction.
package encoder_pkg;

    localparam int LINES  = 8;
    localparam int CODE_W = 3;

    localparam bit MSB_FIRST_DEF = 1'b1;

endpackage

// File: rtl/encoder83_serializer_priority_enc83.sv
// Combinational 8-to-3 priority encoder.
// Returns the winning index, an any flag and the one-hot grant mask.
module priority_enc83
    import encoder_pkg::*;
#(
    parameter bit MSB_FIRST = MSB_FIRST_DEF
) (
    input  logic [LINES-1:0]  vec,
    output logic [CODE_W-1:0] idx,
    output logic              any,
    output logic [LINES-1:0]  grant_mask
);

    always_comb begin
        idx = '0;
        any = |vec;
        // Scan toward the winner so the highest-priority hit is assigned last.
        if (MSB_FIRST) begin
            for (int i = 0; i < LINES; i++) begin
                if (vec[i]) idx = CODE_W'(i);
            end
        end else begin
            for (int i = LINES - 1; i >= 0; i--) begin
                if (vec[i]) idx = CODE_W'(i);
            end
        end
        grant_mask = any ? (LINES'(1) << idx) : '0;
    end

endmodule

// File: rtl/encoder83_serializer.sv
// Registered 8-to-3 priority encoder with valid/ready output.
// Latches request pulses into a pending set and issues one code per transfer.
module encoder83_serializer
    import encoder_pkg::*;
#(
    parameter bit MSB_FIRST = MSB_FIRST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LINES-1:0]  req,
    input  logic              ready,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic [LINES-1:0]  pending,
    output logic              ovf,
    input  logic              ovf_clr
);

    logic [CODE_W-1:0] enc_idx;
    logic              enc_any;
    logic [LINES-1:0]  enc_mask;
    logic              load;
    logic [LINES-1:0]  grant_mask;
    logic              ovf_hit;

    priority_enc83 #(
        .MSB_FIRST (MSB_FIRST)
    ) u_enc (
        .vec        (pending),
        .idx        (enc_idx),
        .any        (enc_any),
        .grant_mask (enc_mask)
    );

    assign load       = !valid || ready;
    assign grant_mask = load ? enc_mask : '0;
    // A req on the bit being granted is a fresh event, not a merge.
    assign ovf_hit    = |(req & pending & ~grant_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            code    <= '0;
            valid   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            pending <= (pending & ~grant_mask) | req;
            if (load) begin
                valid <= enc_any;
                if (enc_any) code <= enc_idx;
            end
            if (ovf_hit) ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_encoder83_serializer.sv
// Self-checking bench: both priority directions against a behavioural model.
module tb_encoder83_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic       ready = 1'b0;
    logic       ovf_clr = 1'b0;

    logic [2:0] code_m, code_l;
    logic       valid_m, valid_l;
    logic [7:0] pend_m, pend_l;
    logic       ovf_m, ovf_l;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state, index 1 = MSB_FIRST, index 0 = LSB first
    logic [7:0] m_pend [2];
    logic [2:0] m_code [2];
    logic       m_valid [2];
    logic       m_ovf [2];

    always #5 clk = ~clk;

    encoder83_serializer #(.MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .req(req), .ready(ready),
        .code(code_m), .valid(valid_m), .pending(pend_m),
        .ovf(ovf_m), .ovf_clr(ovf_clr)
    );

    encoder83_serializer #(.MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .req(req), .ready(ready),
        .code(code_l), .valid(valid_l), .pending(pend_l),
        .ovf(ovf_l), .ovf_clr(ovf_clr)
    );

    function automatic int pick(logic [7:0] p, bit msb);
        if (msb) begin
            for (int i = 7; i >= 0; i--) if (p[i]) return i;
        end else begin
            for (int i = 0; i < 8; i++) if (p[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = '0; m_code[k] = '0;
            m_valid[k] = 1'b0; m_ovf[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic [7:0] g;
            int b;
            g = '0;
            if (!m_valid[k] || ready) begin
                b = pick(m_pend[k], k == 1);
                if (b >= 0) begin
                    g = 8'(1 << b);
                    m_code[k] = 3'(b);
                    m_valid[k] = 1'b1;
                end else begin
                    m_valid[k] = 1'b0;
                end
            end
            if ((req & m_pend[k] & ~g) != 0) m_ovf[k] = 1'b1;
            else if (ovf_clr) m_ovf[k] = 1'b0;
            m_pend[k] = (m_pend[k] & ~g) | req;
        end
    endtask

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("m.valid", 8'(valid_m), 8'(m_valid[1]));
        if (m_valid[1]) chk("m.code", 8'(code_m), 8'(m_code[1]));
        chk("m.pending", pend_m, m_pend[1]);
        chk("m.ovf", 8'(ovf_m), 8'(m_ovf[1]));
        chk("l.valid", 8'(valid_l), 8'(m_valid[0]));
        if (m_valid[0]) chk("l.code", 8'(code_l), 8'(m_code[0]));
        chk("l.pending", pend_l, m_pend[0]);
        chk("l.ovf", 8'(ovf_l), 8'(m_ovf[0]));
    endtask

    // Inputs change at negedge; model steps on posedge; compare at next negedge
    task automatic cyc(logic [7:0] r, logic rd, logic clr = 1'b0);
        req = r; ready = rd; ovf_clr = clr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst.pending", pend_m, 8'h00);
        chk("rst.valid", 8'(valid_m), 8'h00);
        chk("rst.code", 8'(code_m), 8'h00);
        chk("rst.ovf", 8'(ovf_m), 8'h00);
        rst = 1'b0;

        // single event
        cyc(8'h08, 1'b1);
        chk("single.edge1.valid", 8'(valid_m), 8'h00);
        cyc(8'h00, 1'b1);
        chk("single.valid", 8'(valid_m), 8'h01);
        chk("single.code", 8'(code_m), 8'h03);
        cyc(8'h00, 1'b1);
        chk("single.done", 8'(valid_m), 8'h00);
        chk("single.pend", pend_m, 8'h00);

        // simultaneous events, both directions
        cyc(8'h81, 1'b1);
        cyc(8'h00, 1'b1);
        chk("sim.m.first", 8'(code_m), 8'h07);
        chk("sim.l.first", 8'(code_l), 8'h00);
        cyc(8'h00, 1'b1);
        chk("sim.m.second", 8'(code_m), 8'h00);
        chk("sim.l.second", 8'(code_l), 8'h07);
        chk("sim.valid2", 8'(valid_m), 8'h01);
        cyc(8'h00, 1'b1);
        chk("sim.done", 8'(valid_m), 8'h00);

        // backpressure
        cyc(8'h24, 1'b0);
        repeat (10) cyc(8'h00, 1'b0);
        chk("bp.code", 8'(code_m), 8'h05);
        chk("bp.valid", 8'(valid_m), 8'h01);
        chk("bp.pend", pend_m, 8'h04);
        cyc(8'h00, 1'b1);
        chk("bp.next", 8'(code_m), 8'h02);
        cyc(8'h00, 1'b1);
        chk("bp.done", 8'(valid_m), 8'h00);

        // overflow and set-wins clear
        cyc(8'h10, 1'b0);
        cyc(8'h00, 1'b0);
        chk("ovf.hold", 8'(code_m), 8'h04);
        cyc(8'h11, 1'b0);
        chk("ovf.none", 8'(ovf_m), 8'h00);
        cyc(8'h11, 1'b0);
        chk("ovf.set", 8'(ovf_m), 8'h01);
        cyc(8'h01, 1'b0, 1'b1);
        chk("ovf.setwins", 8'(ovf_m), 8'h01);
        cyc(8'h00, 1'b0, 1'b1);
        chk("ovf.clr", 8'(ovf_m), 8'h00);
        repeat (4) cyc(8'h00, 1'b1);

        // grant/request collision
        cyc(8'h02, 1'b1);
        cyc(8'h02, 1'b1);
        chk("col.code", 8'(code_m), 8'h01);
        chk("col.pend", pend_m, 8'h02);
        chk("col.ovf", 8'(ovf_m), 8'h00);
        cyc(8'h00, 1'b1);
        chk("col.again", 8'(code_m), 8'h01);
        chk("col.valid", 8'(valid_m), 8'h01);
        cyc(8'h00, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [7:0] r;
            r = 8'($urandom) & 8'($urandom) & 8'($urandom);
            cyc(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0));
        end
        repeat (10) cyc(8'h00, 1'b1);

        // asynchronous reset mid-transfer
        cyc(8'hFF, 1'b1);
        repeat (4) cyc(8'h00, 1'b1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("arst.pend", pend_m, 8'h00);
        chk("arst.valid", 8'(valid_m), 8'h00);
        chk("arst.code", 8'(code_m), 8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            cyc(8'h00, 1'b1);
            chk("arst.quiet", 8'(valid_m), 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
